// File: rtl/round_robin_arbiter_variable_time_slice.sv
// Four-requester round-robin arbiter with a per-requester time slice and direct owner handoff.
// Optional RRA_SLICE_CNT_EN exposes the slice counter (SLICE_CNT) and a last-cycle flag (SLICE_LAST).
module round_robin_arbiter_variable_time_slice #(
    parameter int unsigned SLICE0 = 1,
    parameter int unsigned SLICE1 = 2,
    parameter int unsigned SLICE2 = 3,
    parameter int unsigned SLICE3 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    output logic [3:0] GNT
`ifdef RRA_SLICE_CNT_EN
    ,
    output logic [3:0] SLICE_CNT,
    output logic       SLICE_LAST
`endif
);

    // A slice of 0 behaves as 1; anything above the 4-bit counter range saturates.
    localparam logic [3:0] SliceEff0 = (SLICE0 == 0) ? 4'd1 : (SLICE0 > 15) ? 4'd15 : 4'(SLICE0);
    localparam logic [3:0] SliceEff1 = (SLICE1 == 0) ? 4'd1 : (SLICE1 > 15) ? 4'd15 : 4'(SLICE1);
    localparam logic [3:0] SliceEff2 = (SLICE2 == 0) ? 4'd1 : (SLICE2 > 15) ? 4'd15 : 4'(SLICE2);
    localparam logic [3:0] SliceEff3 = (SLICE3 == 0) ? 4'd1 : (SLICE3 > 15) ? 4'd15 : 4'(SLICE3);

    logic [3:0] gnt_q, gnt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] own;
    logic [1:0] win;
    logic [3:0] own_slice;

    // Circular scan from k+1; k itself is checked last. Only called with req != 0.
    function automatic logic [1:0] next_idx(input logic [1:0] k, input logic [3:0] req);
        logic [1:0] idx;
        next_idx = k;
        for (int j = 4; j >= 1; j--) begin
            idx = k + 2'(j);
            if (req[idx]) next_idx = idx;
        end
    endfunction

    always_comb begin
        own = 2'd0;
        unique case (gnt_q)
            4'b0010: own = 2'd1;
            4'b0100: own = 2'd2;
            4'b1000: own = 2'd3;
            default: own = 2'd0;
        endcase
    end

    always_comb begin
        own_slice = SliceEff0;
        case (own)
            2'd1:    own_slice = SliceEff1;
            2'd2:    own_slice = SliceEff2;
            2'd3:    own_slice = SliceEff3;
            default: own_slice = SliceEff0;
        endcase
    end

    always_comb begin
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        win   = 2'd0;
        if (gnt_q == 4'b0000) begin
            if (REQ != 4'b0000) begin
                win   = next_idx(ptr_q, REQ);
                gnt_d = 4'b0001 << win;
                cnt_d = 4'd1;
                ptr_d = win;
            end
        end else if (!REQ[own] || (cnt_q >= own_slice)) begin
            // Release or slice expiry: hand off in this same edge, possibly back to the owner.
            if (REQ == 4'b0000) begin
                gnt_d = 4'b0000;
                cnt_d = 4'd0;
            end else begin
                win   = next_idx(own, REQ);
                gnt_d = 4'b0001 << win;
                cnt_d = 4'd1;
                ptr_d = win;
            end
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q <= 4'b0000;
            cnt_q <= 4'd0;
            ptr_q <= 2'd3;
        end else begin
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign GNT = gnt_q;

`ifdef RRA_SLICE_CNT_EN
    assign SLICE_CNT  = cnt_q;
    assign SLICE_LAST = (gnt_q != 4'b0000) && (cnt_q == own_slice);
`else
`endif

endmodule

// File: tb/tb_round_robin_arbiter_variable_time_slice.sv
// Bench for round_robin_arbiter_variable_time_slice: directed vector table, reset cases,
// then random REQ traffic against a behavioural arbiter model (default slices 1,2,3,4).
module tb_round_robin_arbiter_variable_time_slice;

    logic       clk;
    logic       rst_n;
    logic [3:0] REQ;
    logic [3:0] GNT;
`ifdef RRA_SLICE_CNT_EN
    logic [3:0] SLICE_CNT;
    logic       SLICE_LAST;
`endif

    round_robin_arbiter_variable_time_slice dut (
        .clk   (clk),
        .rst_n (rst_n),
        .REQ   (REQ),
        .GNT   (GNT)
`ifdef RRA_SLICE_CNT_EN
        ,
        .SLICE_CNT  (SLICE_CNT),
        .SLICE_LAST (SLICE_LAST)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] gnt;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    // Model state: owner index (-1 = idle), cycles used in current slice, last grantee.
    int m_own;
    int m_cnt;
    int m_ptr;
    int slice_len[4] = '{1, 2, 3, 4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input int k, input logic [3:0] r);
        for (int off = 1; off <= 4; off++) begin
            if (r[(k + off) % 4]) return (k + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        return (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
    endfunction

    task automatic model_reset();
        m_own = -1;
        m_cnt = 0;
        m_ptr = 3;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_own < 0) begin
            w = search(m_ptr, r);
            if (w >= 0) begin
                m_own = w; m_cnt = 1; m_ptr = w;
            end
        end else if (r[m_own] && m_cnt < slice_len[m_own]) begin
            m_cnt++;
        end else begin
            w = search(m_own, r);
            if (w < 0) begin
                m_own = -1; m_cnt = 0;
            end else begin
                m_own = w; m_cnt = 1; m_ptr = w;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".gnt"}, {28'b0, GNT}, {28'b0, model_gnt()});
        check({tag, ".onehot"}, {31'b0, $onehot0(GNT)}, 32'd1);
`ifdef RRA_SLICE_CNT_EN
        check({tag, ".cnt"}, {28'b0, SLICE_CNT}, m_cnt);
        check({tag, ".last"}, {31'b0, SLICE_LAST},
              {31'b0, (m_own >= 0) && (m_cnt == slice_len[m_own])});
`endif
    endtask

    // Async reset asserted between edges; GNT must clear without a clock edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset.gnt_async", {28'b0, GNT}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [3:0] r);
        REQ = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic add(input bit rst, input logic [3:0] req, input logic [3:0] gnt, input int cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.gnt = gnt; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        REQ   = 4'b0000;
        model_reset();
        #12;
        check("reset.gnt_initial", {28'b0, GNT}, 32'd0);
        rst_n = 1'b1;

        // Reset mid-grant while GNT=0100.
        step(4'b0100);
        check("rst_mid.pre", {28'b0, GNT}, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.immediate", {28'b0, GNT}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_mid.held", {28'b0, GNT}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000);
        check("rst_mid.after", {28'b0, GNT}, 32'h0);

        // Single requester: re-granted every slice with no gap, then idle.
        add(1, 4'b0001, 4'b0001, 1);
        for (int i = 0; i < 3; i++) add(0, 4'b0001, 4'b0001, 1);
        add(0, 4'b0000, 4'b0000, 0);
        // Full contention: 1x0001, 2x0010, 3x0100, 4x1000, then repeats.
        add(1, 4'b1111, 4'b0001, 1);
        add(0, 4'b1111, 4'b0010, 1);
        add(0, 4'b1111, 4'b0010, 2);
        for (int i = 1; i <= 3; i++) add(0, 4'b1111, 4'b0100, i);
        for (int i = 1; i <= 4; i++) add(0, 4'b1111, 4'b1000, i);
        add(0, 4'b1111, 4'b0001, 1);
        add(0, 4'b1111, 4'b0010, 1);
        // Early release from 1000 at CNT=1.
        add(1, 4'b1111, 4'b0001, 1);
        add(0, 4'b1111, 4'b0010, 1);
        add(0, 4'b1111, 4'b0010, 2);
        for (int i = 1; i <= 3; i++) add(0, 4'b1111, 4'b0100, i);
        add(0, 4'b1111, 4'b1000, 1);
        add(0, 4'b0110, 4'b0010, 1);
        // 0010 expiring with REQ=0011 wraps to 0001.
        add(1, 4'b0011, 4'b0001, 1);
        add(0, 4'b0011, 4'b0010, 1);
        add(0, 4'b0011, 4'b0010, 2);
        add(0, 4'b0011, 4'b0001, 1);
        // 0010 expiring with REQ=0110 moves to 0100.
        add(1, 4'b0010, 4'b0010, 1);
        add(0, 4'b0110, 4'b0010, 2);
        add(0, 4'b0110, 4'b0100, 1);
        // Handoff sequence from idle.
        add(1, 4'b0011, 4'b0001, 1);
        add(0, 4'b0110, 4'b0010, 1);
        add(0, 4'b1110, 4'b0010, 2);
        add(0, 4'b1111, 4'b0100, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset();
            step(vecs[i].req);
            check($sformatf("vec%0d.gnt", i), {28'b0, GNT}, {28'b0, vecs[i].gnt});
`ifdef RRA_SLICE_CNT_EN
            check($sformatf("vec%0d.cnt", i), {28'b0, SLICE_CNT}, vecs[i].cnt);
`endif
        end

        // Random traffic against the model, with occasional async resets.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic [3:0] prev_req;
            if ($urandom_range(0, 99) < 2) apply_reset();
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b1111;
            prev_req = r;
            step(r);
            check_model($sformatf("rand%0d", i));
            check($sformatf("rand%0d.gnt_in_req", i), {28'b0, GNT & ~prev_req}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
